// File: rtl/lvds_cap_pkg.sv
// Shared constants, encodings and types for the lvds1 capture writer.
package lvds_cap_pkg;

  localparam int unsigned NCH      = 14;
  localparam int unsigned SAMPW    = 10;
  localparam int unsigned DATAW    = NCH * SAMPW;
  localparam int unsigned USEDW    = 11;
  localparam int unsigned HEADROOM = 1020;
  localparam int unsigned LENW     = 16;

  typedef enum logic [1:0] {
    TRIG_IMM     = 2'd0,
    TRIG_LEVEL   = 2'd1,
    TRIG_EXT     = 2'd2,
    TRIG_IMM_ALT = 2'd3
  } trig_mode_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  typedef struct packed {
    logic [LENW-1:0]  length;
    trig_mode_e       mode;
    logic [SAMPW-1:0] level;
  } cap_cfg_t;

endpackage

// File: rtl/sync2.sv
// Two-flop level synchronizer into the clklvds domain, cleared by reset.
module sync2 (
  input  logic clklvds,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/lvds_capture_writer.sv
// lvds1 sample FIFO producer: arm via toggle, wait for trigger, write length words
// with almost-full flow control, report completion with a toggle.
module lvds_capture_writer
  import lvds_cap_pkg::*;
(
  input  logic             clklvds,
  input  logic             rstn,
  input  logic             arm_tgl,
  input  logic [LENW-1:0]  length_cfg,
  input  logic [1:0]       trig_mode,
  input  logic [SAMPW-1:0] trig_level,
  input  logic             ext_trig,
  input  logic [DATAW-1:0] lvds_bits,
  input  logic [USEDW-1:0] fifo_wrused,
  input  logic             fifo_wrfull,
  output logic             fifo_wr,
  output logic [DATAW-1:0] fifo_data,
  output logic             done_tgl,
  output logic             armed,
  output logic             busy,
  output logic [LENW-1:0]  drop_cnt
);

  localparam logic [1:0] SETTLED = 2'd3;

  logic             arm_sync, arm_prev, ext_sync, ext_prev;
  logic [1:0]       settle;
  logic             arm_edge, ext_rise, trig_fire, room, active, last_word;
  state_e           state, state_d;
  cap_cfg_t         cfg;
  logic [LENW-1:0]  cnt, cnt_d, cnt_inc, drop_d;
  logic [SAMPW-1:0] prev_ch0, prev_ch0_d, cur_ch0;
  logic             wr_d, done_d;

  sync2 u_sync_arm (.clklvds(clklvds), .rstn(rstn), .d(arm_tgl),  .q(arm_sync));
  sync2 u_sync_ext (.clklvds(clklvds), .rstn(rstn), .d(ext_trig), .q(ext_sync));

  // Edges are ignored until a toggle level held across reset has reached arm_prev.
  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn)                settle <= 2'd0;
    else if (settle != SETTLED) settle <= settle + 2'd1;
  end

  assign arm_edge  = (settle == SETTLED) && (arm_sync ^ arm_prev);
  assign ext_rise  = ext_sync & ~ext_prev;
  assign cur_ch0   = lvds_bits[SAMPW-1:0];
  assign room      = (fifo_wrused < USEDW'(HEADROOM)) && !fifo_wrfull;
  assign active    = ((state == S_ARMED) && trig_fire) || (state == S_CAPTURE);
  assign cnt_inc   = cnt + LENW'(1);
  assign last_word = active && room && (cnt_inc == cfg.length);

  always_comb begin
    trig_fire = 1'b1;
    case (cfg.mode)
      TRIG_LEVEL: trig_fire = (prev_ch0 < cfg.level) && (cur_ch0 >= cfg.level);
      TRIG_EXT:   trig_fire = ext_rise;
      default:    trig_fire = 1'b1;
    endcase
  end

  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_d;
  end

  // An arm edge restarts the FSM from any state.
  always_comb begin
    state_d = state;
    if (arm_edge) begin
      state_d = (length_cfg == '0) ? S_IDLE : S_ARMED;
    end else begin
      case (state)
        S_ARMED:   if (trig_fire) state_d = last_word ? S_IDLE : S_CAPTURE;
        S_CAPTURE: if (last_word) state_d = S_IDLE;
        default:   state_d = state;
      endcase
    end
  end

  always_comb begin
    wr_d       = 1'b0;
    cnt_d      = cnt;
    drop_d     = drop_cnt;
    done_d     = done_tgl;
    prev_ch0_d = prev_ch0;
    if (arm_edge) begin
      cnt_d      = '0;
      drop_d     = '0;
      prev_ch0_d = '1;
      if (length_cfg == '0) done_d = ~done_tgl;
    end else begin
      if (state == S_ARMED) prev_ch0_d = cur_ch0;
      if (active) begin
        if (room) begin
          wr_d  = 1'b1;
          cnt_d = cnt_inc;
          if (last_word) done_d = ~done_tgl;
        end else begin
          drop_d = (drop_cnt == '1) ? drop_cnt : drop_cnt + LENW'(1);
        end
      end
    end
  end

  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) begin
      fifo_wr   <= 1'b0;
      fifo_data <= '0;
      done_tgl  <= 1'b0;
      armed     <= 1'b0;
      busy      <= 1'b0;
      drop_cnt  <= '0;
      cnt       <= '0;
      prev_ch0  <= '1;
      cfg       <= '0;
      arm_prev  <= 1'b0;
      ext_prev  <= 1'b0;
    end else begin
      fifo_wr  <= wr_d;
      if (wr_d) fifo_data <= lvds_bits;
      done_tgl <= done_d;
      armed    <= (state_d == S_ARMED);
      busy     <= (state_d != S_IDLE);
      drop_cnt <= drop_d;
      cnt      <= cnt_d;
      prev_ch0 <= prev_ch0_d;
      if (arm_edge) cfg <= '{length: length_cfg, mode: trig_mode_e'(trig_mode), level: trig_level};
      arm_prev <= arm_sync;
      ext_prev <= ext_sync;
    end
  end

endmodule
